// File: rtl/bitwise_stream_alu.sv
// Pipelined bitwise stream ALU: per-beat AND/OR/XOR/XNOR with an optional
// packet-accumulate mode and a single registered valid/ready output stage.

package bitwise_stream_alu_pkg;
    typedef enum logic [1:0] {
        AND_OP  = 2'd0,
        OR_OP   = 2'd1,
        XOR_OP  = 2'd2,
        XNOR_OP = 2'd3
    } mode_t;
endpackage

module bitwise_stream_alu
    import bitwise_stream_alu_pkg::*;
#(
    parameter int unsigned N     = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    input  mode_t            mode,
    input  logic             accum,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     result,
    output logic [CNT_W-1:0] out_count
);

    typedef enum logic [0:0] {StIdle, StAccum} state_e;

    state_e           state_q, state_d;
    mode_t            pkt_mode_q, pkt_mode_d;
    logic [N-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             accept;
    logic             take;
    mode_t            eff_mode;
    logic [N-1:0]     r;
    logic [N-1:0]     folded;
    logic [CNT_W-1:0] cnt_inc;
    logic             load;
    logic [N-1:0]     load_val;
    logic [CNT_W-1:0] load_cnt;

    // Handshakes; a held output blocks every beat, including non-last ones mid-packet.
    always_comb begin
        in_ready = !out_valid || out_ready;
        accept   = in_valid && in_ready;
        take     = out_valid && out_ready;
    end

    // Per-beat operation; mid-packet beats use the mode latched on the first beat.
    always_comb begin
        eff_mode = (state_q == StAccum) ? pkt_mode_q : mode;
        unique case (eff_mode)
            AND_OP:  r = a & b;
            OR_OP:   r = a | b;
            XOR_OP:  r = a ^ b;
            XNOR_OP: r = ~(a ^ b);
            default: r = '0;
        endcase
    end

    // Fold into the accumulator; both XOR flavours fold with XOR. Count saturates.
    always_comb begin
        unique case (pkt_mode_q)
            AND_OP:  folded = acc_q & r;
            OR_OP:   folded = acc_q | r;
            XOR_OP:  folded = acc_q ^ r;
            XNOR_OP: folded = acc_q ^ r;
            default: folded = acc_q;
        endcase
        cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
    end

    // Next-state logic and output-load decision.
    always_comb begin
        state_d    = state_q;
        pkt_mode_d = pkt_mode_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        load       = 1'b0;
        load_val   = r;
        load_cnt   = CNT_W'(1);
        if (accept) begin
            unique case (state_q)
                StIdle: begin
                    if (!accum) begin
                        load = 1'b1;
                    end else begin
                        pkt_mode_d = mode;
                        acc_d      = r;
                        cnt_d      = CNT_W'(1);
                        if (in_last) begin
                            load = 1'b1;
                        end else begin
                            state_d = StAccum;
                        end
                    end
                end
                StAccum: begin
                    acc_d = folded;
                    cnt_d = cnt_inc;
                    if (in_last) begin
                        load     = 1'b1;
                        load_val = folded;
                        load_cnt = cnt_inc;
                        state_d  = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Packet state registers.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q    <= StIdle;
            pkt_mode_q <= AND_OP;
            acc_q      <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pkt_mode_q <= pkt_mode_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
        end
    end

    // Output register: a load wins over a take, so a simultaneous take+load keeps valid high.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            out_valid <= 1'b0;
            result    <= '0;
            out_count <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            result    <= load_val;
            out_count <= load_cnt;
        end else if (take) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bitwise_stream_alu.sv
// Scoreboard bench for bitwise_stream_alu: two instances share stimulus, one with
// CNT_W=8 and one with CNT_W=2 to exercise count saturation.
module tb_bitwise_stream_alu;
    import bitwise_stream_alu_pkg::*;

    logic       clk = 1'b0;
    logic       rstN = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    mode_t      mode = AND_OP;
    logic       accum = 1'b0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       out_ready = 1'b1;

    logic       in_ready, out_valid;
    logic [7:0] result, out_count;
    logic       in_ready2, out_valid2;
    logic [7:0] result2;
    logic [1:0] out_count2;

    int n_vec = 0;
    int n_fail = 0;

    logic [7:0] exp_res_q[$];
    logic [7:0] exp_cnt_q[$];
    logic [7:0] exp_res2_q[$];
    logic [1:0] exp_cnt2_q[$];

    bitwise_stream_alu #(.N(8), .CNT_W(8)) dut (
        .clk(clk), .rstN(rstN), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .mode(mode), .accum(accum), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .out_count(out_count)
    );

    bitwise_stream_alu #(.N(8), .CNT_W(2)) dut_sat (
        .clk(clk), .rstN(rstN), .in_valid(in_valid), .in_ready(in_ready2),
        .in_last(in_last), .mode(mode), .accum(accum), .a(a), .b(b),
        .out_valid(out_valid2), .out_ready(out_ready), .result(result2),
        .out_count(out_count2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_out(input logic [7:0] res, input logic [7:0] cnt, input logic [1:0] cnt2);
        exp_res_q.push_back(res);
        exp_cnt_q.push_back(cnt);
        exp_res2_q.push_back(res);
        exp_cnt2_q.push_back(cnt2);
    endtask

    // Drive one beat and hold it until accepted; returns #1 after the accepting edge.
    task automatic send(input mode_t m, input logic acc, input logic [7:0] va,
                        input logic [7:0] vb, input logic last);
        logic rdy;
        bit   done = 0;
        mode = m; accum = acc; a = va; b = vb; in_last = last; in_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) done = 1;
        end
        if (!done) check("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Monitor: every take on either instance must match the next expected output.
    always @(negedge clk) begin
        if (rstN && out_valid && out_ready) begin
            if (exp_res_q.size() == 0) begin
                check("spurious_out", {24'd0, result}, 32'hDEAD);
            end else begin
                check("result", {24'd0, result}, {24'd0, exp_res_q.pop_front()});
                check("out_count", {24'd0, out_count}, {24'd0, exp_cnt_q.pop_front()});
            end
        end
        if (rstN && out_valid2 && out_ready) begin
            if (exp_res2_q.size() == 0) begin
                check("spurious_out_sat", {24'd0, result2}, 32'hDEAD);
            end else begin
                check("result_sat", {24'd0, result2}, {24'd0, exp_res2_q.pop_front()});
                check("out_count_sat", {30'd0, out_count2}, {30'd0, exp_cnt2_q.pop_front()});
            end
        end
    end

    logic [7:0] sweep_exp [4];
    mode_t      sweep_mode [4];

    initial begin
        sweep_exp[0] = 8'h30; sweep_exp[1] = 8'hFC; sweep_exp[2] = 8'hCC; sweep_exp[3] = 8'h33;
        sweep_mode[0] = AND_OP; sweep_mode[1] = OR_OP;
        sweep_mode[2] = XOR_OP; sweep_mode[3] = XNOR_OP;

        // Reset state
        #1 rstN = 1'b0;
        #2;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", {24'd0, result}, 32'd0);
        check("rst_out_count", {24'd0, out_count}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        #10 rstN = 1'b1;
        @(posedge clk); #1;

        // Single beats, mode sweep; in_last must be ignored when accum=0
        for (int i = 0; i < 4; i++) begin
            expect_out(sweep_exp[i], 8'd1, 2'd1);
            send(sweep_mode[i], 1'b0, 8'hF0, 8'h3C, i[0]);
            check("latency_valid", {31'd0, out_valid}, 32'd1);
        end
        repeat (2) @(posedge clk);
        #1 check("drained_valid", {31'd0, out_valid}, 32'd0);

        // OR packet with mode/accum toggled mid-packet
        expect_out(8'h83, 8'd3, 2'd3);
        send(OR_OP, 1'b1, 8'h01, 8'h00, 1'b0);
        send(AND_OP, 1'b1, 8'h02, 8'h00, 1'b0);
        check("no_early_out", {31'd0, out_valid}, 32'd0);
        send(AND_OP, 1'b0, 8'h80, 8'h00, 1'b1);
        repeat (2) @(posedge clk); #1;

        // Back-pressure
        out_ready = 1'b0;
        expect_out(8'h0F, 8'd1, 2'd1);
        send(AND_OP, 1'b0, 8'hFF, 8'h0F, 1'b0);
        expect_out(8'hFF, 8'd1, 2'd1);
        mode = XOR_OP; accum = 1'b0; a = 8'hAA; b = 8'h55; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_result_hold", {24'd0, result}, 32'h0F);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        check("release_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1 in_valid = 1'b0;
        check("take_load_valid", {31'd0, out_valid}, 32'd1);
        check("take_load_result", {24'd0, result}, 32'hFF);
        repeat (2) @(posedge clk); #1;

        // Count saturation: 5-beat XOR packet
        expect_out(8'h01, 8'd5, 2'd3);
        for (int i = 0; i < 5; i++) send(XOR_OP, 1'b1, 8'h01, 8'h00, i == 4);
        repeat (2) @(posedge clk); #1;

        // Reset mid-packet discards the partial accumulation
        send(XOR_OP, 1'b1, 8'h0F, 8'h00, 1'b0);
        send(XOR_OP, 1'b1, 8'hF0, 8'h00, 1'b0);
        #1 rstN = 1'b0;
        #2 check("midrst_valid", {31'd0, out_valid}, 32'd0);
        #3 rstN = 1'b1;
        repeat (3) @(posedge clk); #1;
        check("midrst_no_out", {31'd0, out_valid}, 32'd0);
        expect_out(8'hFF, 8'd1, 2'd1);
        send(XNOR_OP, 1'b1, 8'h00, 8'h00, 1'b1);
        repeat (3) @(posedge clk); #1;

        check("sb_empty", exp_res_q.size(), 32'd0);
        check("sb_empty_sat", exp_res2_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    // Global time limit
    initial begin
        #100000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1);
    end

endmodule
